// File: rtl/memory_pkg.sv
// Shared memory-subsystem definitions: load/store size encodings, DMEM map,
// error codes and the DMEM controller state type.
package memory_pkg;

    localparam int unsigned ERR_ENUMS_WIDTH = 2;

    localparam logic [1:0] LS_SINGLE   = 2'b00;
    localparam logic [1:0] LS_HALFWORD = 2'b01;
    localparam logic [1:0] LS_WORD     = 2'b10;
    localparam logic       L_UNSIGNED  = 1'b1;

    localparam logic [31:0] IMEM_BYTES = 32'h0000_4000;
    localparam logic [31:0] DMEM_BASE  = IMEM_BYTES;
    localparam int unsigned DMEM_BYTES = 49152;

    typedef enum logic [ERR_ENUMS_WIDTH-1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_RANGE    = 2'b10,
        ERR_RSVD     = 2'b11
    } e_mem_err;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } e_dmem_state;

    // Access footprint in bytes; any size with bit 1 set is a word.
    function automatic logic [2:0] ls_size_bytes(input logic [1:0] n_bytes);
        if (n_bytes[1])      return 3'd4;
        else if (n_bytes[0]) return 3'd2;
        else                 return 3'd1;
    endfunction

endpackage

// File: rtl/dmem_ls_align.sv
// Combinational byte-lane logic for the DMEM load/store path: byte enables,
// store-data replication, load extraction/extension and alignment check.
module dmem_ls_align
    import memory_pkg::*;
(
    input  logic [1:0]  n_bytes,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [31:0] shifted;

    // NOTE: every output gets a default first so no path through the
    // branches below can leave a value held, which would infer a latch.
    always_comb begin
        byte_en     = 4'b0000;
        wdata_lanes = wdata;
        rdata_ext   = rword;
        misaligned  = 1'b0;
        shifted     = rword >> {lane, 3'b000};

        if (n_bytes[1]) begin
            byte_en    = 4'b1111;
            misaligned = (lane != 2'b00);
        end else if (n_bytes == LS_HALFWORD) begin
            byte_en     = 4'b0011 << lane;
            wdata_lanes = {2{wdata[15:0]}};
            rdata_ext   = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            misaligned  = lane[0];
        end else begin
            byte_en     = 4'b0001 << lane;
            wdata_lanes = {4{wdata[7:0]}};
            rdata_ext   = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
        end
    end

endmodule

// File: rtl/dmem_ls_ctrl.sv
// DMEM load/store controller: one outstanding request over valid/ready,
// byte-lane steering, range/alignment errors and configurable response latency.
module dmem_ls_ctrl #(
    parameter int unsigned                MEM_WORD_WIDTH = 32,
    parameter int unsigned                MEM_ADDR_WIDTH = 32,
    parameter logic [MEM_ADDR_WIDTH-1:0]  DMEM_BASE      = MEM_ADDR_WIDTH'(memory_pkg::DMEM_BASE),
    parameter int unsigned                DMEM_BYTES     = memory_pkg::DMEM_BYTES,
    parameter int unsigned                RSP_LATENCY    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [1:0]                req_n_bytes,
    input  logic                      req_unsigned,
    input  logic [MEM_ADDR_WIDTH-1:0] req_addr,
    input  logic [MEM_WORD_WIDTH-1:0] req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [MEM_WORD_WIDTH-1:0] rsp_rdata,
    output logic [1:0]                rsp_err
);
    import memory_pkg::*;

    localparam int unsigned DMEM_WORDS = DMEM_BYTES / 4;
    localparam int unsigned IDX_W      = $clog2(DMEM_WORDS);
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned AX_W       = MEM_ADDR_WIDTH + 1;

    // One extra bit so base/limit comparisons cannot wrap at the top of the map.
    localparam logic [AX_W-1:0] BASE_X = {1'b0, DMEM_BASE};
    localparam logic [AX_W-1:0] LAST_X = BASE_X + AX_W'(DMEM_BYTES - 1);

    e_dmem_state state;
    e_mem_err    err_q;
    e_mem_err    req_err;
    logic [CNT_W-1:0] cnt;

    logic [MEM_WORD_WIDTH-1:0] mem [DMEM_WORDS];

    logic [AX_W-1:0]  addr_x;
    logic [AX_W-1:0]  end_x;
    logic             out_of_range;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rword;
    logic [3:0]       byte_en;
    logic [31:0]      wdata_lanes;
    logic [31:0]      rdata_ext;
    logic             misaligned;
    logic             accept;

    assign addr_x       = {1'b0, req_addr};
    assign end_x        = addr_x + AX_W'(ls_size_bytes(req_n_bytes) - 3'd1);
    assign out_of_range = (addr_x < BASE_X) || (end_x > LAST_X);
    assign idx          = IDX_W'((req_addr - DMEM_BASE) >> 2);
    assign rword        = mem[idx];

    always_comb begin
        req_err = ERR_NONE;
        if (misaligned)        req_err = ERR_MISALIGN;
        else if (out_of_range) req_err = ERR_RANGE;
    end

    dmem_ls_align u_align (
        .n_bytes     (req_n_bytes),
        .lane        (req_addr[1:0]),
        .is_unsigned (req_unsigned),
        .wdata       (req_wdata),
        .rword       (rword),
        .byte_en     (byte_en),
        .wdata_lanes (wdata_lanes),
        .rdata_ext   (rdata_ext),
        .misaligned  (misaligned)
    );

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_err   = err_q;
    assign accept    = req_valid && req_ready && !rst;

    // NOTE: the storage array has no reset; contents survive rst and only
    // the enabled byte lanes are written when a store is accepted.
    always_ff @(posedge clk) begin
        if (accept && req_we && (req_err == ERR_NONE)) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[idx][b*8 +: 8] <= wdata_lanes[b*8 +: 8];
            end
        end
    end

    // NOTE: all state registers use non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_rdata <= '0;
            err_q     <= ERR_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_err != ERR_NONE) begin
                            rsp_rdata <= '0;
                            err_q     <= req_err;
                            state     <= RESP;
                        end else begin
                            err_q     <= ERR_NONE;
                            rsp_rdata <= req_we ? '0 : rdata_ext;
                            if (RSP_LATENCY == 1) begin
                                state <= RESP;
                            end else begin
                                cnt   <= CNT_W'(RSP_LATENCY - 1);
                                state <= WAIT;
                            end
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ls_ctrl.sv
// Directed bench for dmem_ls_ctrl: one instance at latency 1 for data-path
// and error checks, one at latency 4 for timing, stall and reset behaviour.
module tb_dmem_ls_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Latency-1 instance
    logic        rst_1, req_valid_1, req_ready_1, req_we_1, req_unsigned_1;
    logic [1:0]  req_n_bytes_1, rsp_err_1;
    logic [31:0] req_addr_1, req_wdata_1, rsp_rdata_1;
    logic        rsp_valid_1, rsp_ready_1;

    // Latency-4 instance
    logic        rst_4, req_valid_4, req_ready_4, req_we_4, req_unsigned_4;
    logic [1:0]  req_n_bytes_4, rsp_err_4;
    logic [31:0] req_addr_4, req_wdata_4, rsp_rdata_4;
    logic        rsp_valid_4, rsp_ready_4;

    dmem_ls_ctrl #(.RSP_LATENCY(1)) u_dut1 (
        .clk          (clk),
        .rst          (rst_1),
        .req_valid    (req_valid_1),
        .req_ready    (req_ready_1),
        .req_we       (req_we_1),
        .req_n_bytes  (req_n_bytes_1),
        .req_unsigned (req_unsigned_1),
        .req_addr     (req_addr_1),
        .req_wdata    (req_wdata_1),
        .rsp_valid    (rsp_valid_1),
        .rsp_ready    (rsp_ready_1),
        .rsp_rdata    (rsp_rdata_1),
        .rsp_err      (rsp_err_1)
    );

    dmem_ls_ctrl #(.RSP_LATENCY(4)) u_dut4 (
        .clk          (clk),
        .rst          (rst_4),
        .req_valid    (req_valid_4),
        .req_ready    (req_ready_4),
        .req_we       (req_we_4),
        .req_n_bytes  (req_n_bytes_4),
        .req_unsigned (req_unsigned_4),
        .req_addr     (req_addr_4),
        .req_wdata    (req_wdata_4),
        .rsp_valid    (rsp_valid_4),
        .rsp_ready    (rsp_ready_4),
        .rsp_rdata    (rsp_rdata_4),
        .rsp_err      (rsp_err_4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    // Full transaction on the latency-1 instance; response due one cycle after accept.
    task automatic txn1(input string tag, input logic we, input logic [1:0] nb, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic [1:0] exp_err);
        req_valid_1 = 1'b1; req_we_1 = we; req_n_bytes_1 = nb; req_unsigned_1 = uns;
        req_addr_1 = addr; req_wdata_1 = wdata;
        check({tag, " ready_before"}, 32'(req_ready_1), 32'd1);
        @(posedge clk); #1;
        req_valid_1 = 1'b0;
        check({tag, " rsp_valid"}, 32'(rsp_valid_1), 32'd1);
        check({tag, " req_ready_busy"}, 32'(req_ready_1), 32'd0);
        check({tag, " rdata"}, rsp_rdata_1, exp_rdata);
        check({tag, " err"}, 32'(rsp_err_1), 32'(exp_err));
        rsp_ready_1 = 1'b1;
        @(posedge clk); #1;
        rsp_ready_1 = 1'b0;
        check({tag, " after_hs"}, {30'd0, req_ready_1, rsp_valid_1}, 32'd2);
    endtask

    // Error-free transaction on the latency-4 instance, consumer ready immediately.
    task automatic txn4(input string tag, input logic we, input logic [1:0] nb, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata);
        req_valid_4 = 1'b1; req_we_4 = we; req_n_bytes_4 = nb; req_unsigned_4 = uns;
        req_addr_4 = addr; req_wdata_4 = wdata;
        check({tag, " ready_before"}, 32'(req_ready_4), 32'd1);
        @(posedge clk); #1;
        req_valid_4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check({tag, " early_valid"}, 32'(rsp_valid_4), 32'd0);
            if (i < 2) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        check({tag, " rsp_valid"}, 32'(rsp_valid_4), 32'd1);
        check({tag, " rdata"}, rsp_rdata_4, exp_rdata);
        check({tag, " err"}, 32'(rsp_err_4), 32'd0);
        rsp_ready_4 = 1'b1;
        @(posedge clk); #1;
        rsp_ready_4 = 1'b0;
        check({tag, " after_hs"}, {30'd0, req_ready_4, rsp_valid_4}, 32'd2);
    endtask

    initial begin
        logic seen_valid;

        rst_1 = 1'b1; req_valid_1 = 1'b0; req_we_1 = 1'b0; req_n_bytes_1 = 2'b10;
        req_unsigned_1 = 1'b0; req_addr_1 = '0; req_wdata_1 = '0; rsp_ready_1 = 1'b0;
        rst_4 = 1'b1; req_valid_4 = 1'b0; req_we_4 = 1'b0; req_n_bytes_4 = 2'b10;
        req_unsigned_4 = 1'b0; req_addr_4 = '0; req_wdata_4 = '0; rsp_ready_4 = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        rst_1 = 1'b0; rst_4 = 1'b0;
        check("reset req_ready", 32'(req_ready_1), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid_1), 32'd0);
        check("reset rsp_rdata", rsp_rdata_1, 32'd0);
        check("reset rsp_err", 32'(rsp_err_1), 32'd0);

        // Word store/load round trip and sub-word extension
        txn1("sw_4000", 1'b1, 2'b10, 1'b0, 32'h4000, 32'hDEAD_BEEF, 32'h0, 2'b00);
        txn1("lw_4000", 1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 32'hDEAD_BEEF, 2'b00);
        txn1("lb_4003", 1'b0, 2'b00, 1'b0, 32'h4003, 32'h0, 32'hFFFF_FFDE, 2'b00);
        txn1("lbu_4003", 1'b0, 2'b00, 1'b1, 32'h4003, 32'h0, 32'h0000_00DE, 2'b00);
        txn1("lh_4000", 1'b0, 2'b01, 1'b0, 32'h4000, 32'h0, 32'hFFFF_BEEF, 2'b00);
        txn1("lhu_4002", 1'b0, 2'b01, 1'b1, 32'h4002, 32'h0, 32'h0000_DEAD, 2'b00);

        // Single-lane store
        txn1("sb_4001", 1'b1, 2'b00, 1'b0, 32'h4001, 32'h0000_0055, 32'h0, 2'b00);
        txn1("lw_after_sb", 1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 32'hDEAD_55EF, 2'b00);

        // Errors: misalignment, range, precedence, wide address, erroring store
        txn1("lh_4001_mis", 1'b0, 2'b01, 1'b0, 32'h4001, 32'h0, 32'h0, 2'b01);
        txn1("lw_3ffc_rng", 1'b0, 2'b10, 1'b0, 32'h3FFC, 32'h0, 32'h0, 2'b10);
        txn1("lw_10000_rng", 1'b0, 2'b10, 1'b0, 32'h1_0000, 32'h0, 32'h0, 2'b10);
        txn1("lw_4002_prec", 1'b0, 2'b10, 1'b0, 32'h4002, 32'h0, 32'h0, 2'b01);
        txn1("lw_fffffffc_rng", 1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 2'b10);
        txn1("sw_4002_mis", 1'b1, 2'b10, 1'b0, 32'h4002, 32'h0, 32'h0, 2'b01);
        txn1("lw_after_errs", 1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 32'hDEAD_55EF, 2'b00);

        // Halfword store ignores upper wdata bits; positive signed halfword
        txn1("sh_4002", 1'b1, 2'b01, 1'b0, 32'h4002, 32'hAAAA_7F01, 32'h0, 2'b00);
        txn1("lw_after_sh", 1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 32'h7F01_55EF, 2'b00);
        txn1("lh_4002_pos", 1'b0, 2'b01, 1'b0, 32'h4002, 32'h0, 32'h0000_7F01, 2'b00);

        // Top edge of the region
        txn1("sw_fffc", 1'b1, 2'b10, 1'b0, 32'hFFFC, 32'h89AB_CDEF, 32'h0, 2'b00);
        txn1("lhu_fffe", 1'b0, 2'b01, 1'b1, 32'hFFFE, 32'h0, 32'h0000_89AB, 2'b00);
        txn1("lb_ffff", 1'b0, 2'b00, 1'b0, 32'hFFFF, 32'h0, 32'hFFFF_FF89, 2'b00);
        txn1("lb_10000_rng", 1'b0, 2'b00, 1'b0, 32'h1_0000, 32'h0, 32'h0, 2'b10);

        // Latency 4 with a stalled consumer and an extra request during WAIT/RESP
        txn4("l4_sw_4010", 1'b1, 2'b10, 1'b0, 32'h4010, 32'hCAFE_F00D, 32'h0);
        req_valid_4 = 1'b1; req_we_4 = 1'b0; req_n_bytes_4 = 2'b10; req_addr_4 = 32'h4010;
        @(posedge clk); #1;
        req_valid_4 = 1'b0;
        check("l4_stall wait_ready", 32'(req_ready_4), 32'd0);
        @(posedge clk); #1;
        req_valid_4 = 1'b1; req_we_4 = 1'b1; req_addr_4 = 32'h4010; req_wdata_4 = 32'h0;
        @(posedge clk); #1;
        check("l4_stall valid_at_2", 32'(rsp_valid_4), 32'd0);
        check("l4_stall ready_at_2", 32'(req_ready_4), 32'd0);
        @(posedge clk); #1;
        check("l4_stall valid_at_3", 32'(rsp_valid_4), 32'd1);
        check("l4_stall rdata", rsp_rdata_4, 32'hCAFE_F00D);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("l4_stall hold_valid", 32'(rsp_valid_4), 32'd1);
            check("l4_stall hold_rdata", rsp_rdata_4, 32'hCAFE_F00D);
            check("l4_stall hold_err", 32'(rsp_err_4), 32'd0);
            check("l4_stall hold_ready", 32'(req_ready_4), 32'd0);
        end
        rsp_ready_4 = 1'b1; req_valid_4 = 1'b0;
        @(posedge clk); #1;
        rsp_ready_4 = 1'b0;
        check("l4_stall after_hs", {30'd0, req_ready_4, rsp_valid_4}, 32'd2);
        txn4("l4_lw_not_clobbered", 1'b0, 2'b10, 1'b0, 32'h4010, 32'h0, 32'hCAFE_F00D);

        // Reset during WAIT discards the response but keeps committed stores
        txn4("l4_sw_4020", 1'b1, 2'b10, 1'b0, 32'h4020, 32'h0BAD_CAFE, 32'h0);
        req_valid_4 = 1'b1; req_we_4 = 1'b0; req_n_bytes_4 = 2'b10; req_addr_4 = 32'h4020;
        @(posedge clk); #1;
        req_valid_4 = 1'b0;
        @(posedge clk); #1;
        rst_4 = 1'b1;
        @(posedge clk); #1;
        rst_4 = 1'b0;
        check("l4_rst valid", 32'(rsp_valid_4), 32'd0);
        check("l4_rst ready", 32'(req_ready_4), 32'd1);
        seen_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen_valid = seen_valid | rsp_valid_4;
        end
        check("l4_rst no_late_valid", 32'(seen_valid), 32'd0);
        txn4("l4_lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h4020, 32'h0, 32'h0BAD_CAFE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
